// File: rtl/sha_2_msg_packer.sv
// Front end of the SHA-2 engine: forwards the per-message command as a config word,
// then packs 32-bit message words MSB-first into 512-bit blocks, zero-filling past the end.
module sha_2_msg_packer #(
    parameter int IN_W  = 32,
    parameter int BLK_W = 512
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [63:0]       cmd_size,
    input  logic [1:0]        cmd_scheme,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [63:0]       cfg_size,
    output logic [1:0]        cfg_scheme,
    output logic              cfg_valid,
    input  logic              cfg_ready,
    output logic [BLK_W-1:0]  data_out,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic              err_last,
    output logic              err_size,
    output logic              busy
);
    localparam int NUM_LANES = BLK_W / IN_W;

    typedef enum logic [1:0] {IDLE, CFG, PACK, SEND} state_t;

    state_t state, state_nxt;

    logic [63:0]                          size_q;
    logic [1:0]                           scheme_q;
    logic [58:0]                          words_total;
    logic [58:0]                          word_cnt;
    logic [3:0]                           slot;
    logic [NUM_LANES-1:0][IN_W-1:0]       blk;
    logic                                 err_last_q, err_size_q;

    logic            cmd_hs, in_hs, cfg_hs, out_hs;
    logic            is_final;
    logic [4:0]      rem;
    logic [IN_W-1:0] word_mask;

    assign rem      = size_q[4:0];
    assign is_final = (word_cnt == words_total - 59'd1);
    // Only the final word of a message with a partial tail is trimmed to its upper rem bits.
    assign word_mask = (is_final && rem != 5'd0) ? ~({IN_W{1'b1}} >> rem) : {IN_W{1'b1}};

    assign cmd_hs = cmd_valid & cmd_ready;
    assign in_hs  = in_valid & in_ready;
    assign cfg_hs = cfg_valid & cfg_ready;
    assign out_hs = data_out_valid & data_out_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Handshake outputs decode straight from the state register, never from the valids.
    always_comb begin
        state_nxt      = state;
        cmd_ready      = 1'b0;
        cfg_valid      = 1'b0;
        in_ready       = 1'b0;
        data_out_valid = 1'b0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid && cmd_size != 64'd0) state_nxt = CFG;
            end
            CFG: begin
                cfg_valid = 1'b1;
                if (cfg_ready) state_nxt = PACK;
            end
            PACK: begin
                in_ready = 1'b1;
                if (in_valid && (is_final || slot == 4'(NUM_LANES-1))) state_nxt = SEND;
            end
            SEND: begin
                data_out_valid = 1'b1;
                if (data_out_ready) state_nxt = (word_cnt == words_total) ? IDLE : PACK;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            size_q      <= '0;
            scheme_q    <= '0;
            words_total <= '0;
            word_cnt    <= '0;
            slot        <= '0;
            blk         <= '0;
            err_last_q  <= 1'b0;
            err_size_q  <= 1'b0;
        end else begin
            if (cmd_hs) begin
                if (cmd_size == 64'd0) begin
                    err_size_q <= 1'b1;
                end else begin
                    size_q      <= cmd_size;
                    scheme_q    <= cmd_scheme;
                    words_total <= cmd_size[63:5] + 59'(|cmd_size[4:0]);
                    word_cnt    <= '0;
                    slot        <= '0;
                    blk         <= '0;
                end
            end
            if (in_hs) begin
                // Slot 0 lands in the top lane so the first message bit is data_out[511].
                blk[4'(NUM_LANES-1) - slot] <= in_data & word_mask;
                word_cnt <= word_cnt + 59'd1;
                slot     <= slot + 4'd1;
                if (in_last != is_final) err_last_q <= 1'b1;
            end
            if (out_hs) begin
                blk  <= '0;
                slot <= '0;
            end
        end
    end

    assign cfg_size   = size_q;
    assign cfg_scheme = scheme_q;
    assign data_out   = blk;
    assign err_last   = err_last_q;
    assign err_size   = err_size_q;

endmodule

// File: tb/tb_sha_2_msg_packer.sv
// Randomized bench for sha_2_msg_packer: each message is modelled as a word list
// turned into expected 512-bit blocks, checked alongside handshake and error behaviour.
module tb_sha_2_msg_packer;
    logic         clk, nrst;
    logic [63:0]  cmd_size;
    logic [1:0]   cmd_scheme;
    logic         cmd_valid, cmd_ready;
    logic [31:0]  in_data;
    logic         in_last, in_valid, in_ready;
    logic [63:0]  cfg_size;
    logic [1:0]   cfg_scheme;
    logic         cfg_valid, cfg_ready;
    logic [511:0] data_out;
    logic         data_out_valid, data_out_ready;
    logic         err_last, err_size, busy;

    int n_vec = 0;
    int n_err = 0;
    bit exp_err_last = 0;
    bit exp_err_size = 0;

    sha_2_msg_packer dut (
        .clk(clk), .nrst(nrst),
        .cmd_size(cmd_size), .cmd_scheme(cmd_scheme), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_size(cfg_size), .cfg_scheme(cfg_scheme), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .err_last(err_last), .err_size(err_size), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_cfg_valid"}, cfg_valid, 0);
        chk({tag, "_dov"}, data_out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_errs"}, {err_last, err_size}, 0);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_cfg"}, {cfg_size, cfg_scheme}, 0);
    endtask

    // mode: 0 random words, 1 i+1, 2 AABBCCDD then FFFFFFFF, 3 all FFFFFFFF.
    // bad_last flips the in_last marker on that word index (-1 for none).
    // abort_at stops feeding once that many words are accepted (-1 for a full run).
    task automatic run_msg(input logic [63:0] size, input int mode, input int bad_last,
                           input int cfg_stall, input int out_stall, input bit rnd,
                           input int abort_at);
        logic [31:0]  w [$];
        logic [511:0] eb [0:15];
        logic [31:0]  wd, mask;
        logic [65:0]  cfg_hold;
        logic [511:0] blk_hold;
        logic [1:0]   sch;
        int n, nb, keep, idx, bi, cfg_cnt, out_cnt, budget, t;
        bit cfg_done, seen, exp_dov;

        n    = int'((size + 64'd31) >> 5);
        nb   = int'((size + 64'd511) >> 9);
        keep = int'(size % 64'd32);
        mask = (keep == 0) ? 32'hFFFF_FFFF : 32'(((64'd1 << keep) - 64'd1) << (32 - keep));
        sch  = 2'($urandom_range(0, 3));
        for (int b = 0; b < 16; b++) eb[b] = '0;
        for (int i = 0; i < n; i++) begin
            case (mode)
                1:       wd = 32'(i + 1);
                2:       wd = (i == 0) ? 32'hAABB_CCDD : 32'hFFFF_FFFF;
                3:       wd = 32'hFFFF_FFFF;
                default: wd = $urandom;
            endcase
            w.push_back(wd);
            if (i == n - 1) wd = wd & mask;
            eb[i / 16][511 - 32 * (i % 16) -: 32] = wd;
        end
        if (bad_last >= 0 && bad_last < n) exp_err_last = 1;

        @(negedge clk);
        cmd_valid = 1; cmd_size = size; cmd_scheme = sch;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        chk("cmd_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0;
        chk("cfg_lat", cfg_valid, 1);

        idx = 0; bi = 0; cfg_cnt = 0; out_cnt = 0; cfg_done = 0; seen = 0; exp_dov = 0;
        budget = 200 + n * 8 + nb * (out_stall + 6) + cfg_stall;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (abort_at >= 0 && idx == abort_at) begin
                in_valid = 0;
                return;
            end
            if (idx == n && bi == nb && cfg_done && !busy) break;
            if (bi < nb) chk("cmd_busy", cmd_ready, 0);
            if (exp_dov) chk("dov_lat", data_out_valid, 1);
            exp_dov = 0;

            if (data_out_valid) begin
                if (!seen) begin
                    chk("order", cfg_done, 1);
                    if (bi < nb) chk($sformatf("blk%0d", bi), data_out, eb[bi]);
                    else         chk("blk_cnt", bi + 1, nb);
                    blk_hold = data_out; seen = 1; out_cnt = 0;
                end else begin
                    chk("blk_hold", data_out, blk_hold);
                end
                chk("in_rdy_send", in_ready, 0);
                data_out_ready = (out_cnt >= out_stall) && (!rnd || $urandom_range(0, 2) != 0);
                out_cnt++;
                if (data_out_ready) begin bi++; seen = 0; end
            end else begin
                data_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end

            if (cfg_valid && !cfg_done) begin
                if (cfg_cnt == 0) begin
                    chk("cfg_size", cfg_size, size);
                    chk("cfg_scheme", cfg_scheme, sch);
                    cfg_hold = {cfg_size, cfg_scheme};
                end else begin
                    chk("cfg_hold", {cfg_size, cfg_scheme}, cfg_hold);
                    chk("in_rdy_cfg", in_ready, 0);
                end
                cfg_ready = (cfg_cnt >= cfg_stall);
                cfg_cnt++;
                if (cfg_ready) cfg_done = 1;
            end else begin
                cfg_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end

            if (idx < n) begin
                in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data  = w[idx];
                in_last  = (idx == n - 1) ^ (idx == bad_last);
                if (in_valid && in_ready) begin
                    if ((idx + 1) % 16 == 0 || idx + 1 == n) exp_dov = 1;
                    idx++;
                end
            end else begin
                in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                in_data  = $urandom;
                in_last  = 0;
            end
            @(negedge clk);
        end
        in_valid = 0; cfg_ready = 0; data_out_ready = 0;
        chk("words_done", idx, n);
        chk("blks_done", bi, nb);
        chk("end_busy", busy, 0);
        chk("end_cmd_ready", cmd_ready, 1);
        chk("err_last", err_last, exp_err_last);
        chk("err_size", err_size, exp_err_size);
    endtask

    initial begin
        clk = 0; nrst = 0;
        cmd_size = 0; cmd_scheme = 0; cmd_valid = 0;
        in_data = 0; in_last = 0; in_valid = 0;
        cfg_ready = 0; data_out_ready = 0;
        repeat (2) @(negedge clk);
        chk_rst("rst");
        nrst = 1;
        @(negedge clk);

        run_msg(64'd512, 1, -1, 0, 0, 0, -1);
        run_msg(64'd40, 2, -1, 0, 0, 0, -1);
        run_msg(64'd1100, 3, -1, 0, 0, 1, -1);
        run_msg(64'd1100, 0, -1, 5, 7, 0, -1);

        @(negedge clk);
        cmd_valid = 1; cmd_size = 0; cmd_scheme = 2'd1;
        chk("zero_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0;
        exp_err_size = 1;
        for (int i = 0; i < 4; i++) begin
            chk("zero_err", err_size, exp_err_size);
            chk("zero_cmd_ready", cmd_ready, 1);
            chk("zero_quiet", {cfg_valid, data_out_valid, busy}, 0);
            @(negedge clk);
        end

        run_msg(64'd256, 0, 3, 0, 0, 0, -1);
        run_msg(64'd64, 0, -1, 0, 0, 1, -1);

        for (int m = 0; m < 12; m++)
            run_msg(64'($urandom_range(1, 1800)), 0,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1,
                    $urandom_range(0, 3), $urandom_range(0, 3), 1, -1);

        run_msg(64'd1024, 0, -1, 0, 0, 0, 5);
        nrst = 0;
        #1;
        chk_rst("mid_rst");
        exp_err_last = 0; exp_err_size = 0;
        @(negedge clk);
        nrst = 1;
        run_msg(64'd32, 0, -1, 0, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sha_2_msg_packer.md
Name: sha_2_msg_packer

Overview:
Upstream transmitter for the SHA-2 engine. It accepts a per-message length/scheme command and a 32-bit message word stream. It forwards the command as the engine's config word, then packs the stream MSB-first into 512-bit data blocks and drives them on the engine's data-in handshake. The final block is zero-filled past the message end. Message-end marker and length padding remain the engine's job.

Parameters:
IN_W, 32, input word width; only 32 is supported.
BLK_W, 512, output block width; fixed at 16 x IN_W.

Ports:
clk  input  1  clock
nrst  input  1  reset, asynchronous, active-low
cmd_size  input  64  message length in bits
cmd_scheme  input  2  SHA-2 scheme, passed through unchanged
cmd_valid  input  1  command valid
cmd_ready  output  1  command ready
in_data  input  32  message word, first message bit at in_data[31]
in_last  input  1  final message word marker (checked only)
in_valid  input  1  word valid
in_ready  output  1  word ready
cfg_size  output  64  config size to engine
cfg_scheme  output  2  config scheme to engine
cfg_valid  output  1  config valid
cfg_ready  input  1  config ready
data_out  output  512  packed block to engine
data_out_valid  output  1  block valid
data_out_ready  input  1  block ready
err_last  output  1  sticky: in_last disagrees with cmd_size
err_size  output  1  sticky: zero-length command received
busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE; all registers zero. cfg_valid=0, data_out_valid=0, in_ready=0, cmd_ready=1, err_*=0, busy=0.
- Outputs are decoded from registered state; there is no combinational valid-to-ready path. Handshake = valid & ready on a rising edge.
- Derived on command accept:
  - words_total = (cmd_size>>5) + |cmd_size[4:0], held in a 59-bit register.
  - rem = cmd_size[4:0].
- IDLE: cmd_ready=1.
  - Command handshake with cmd_size!=0: capture size/scheme; word_cnt=0; slot=0; block register=0; go to CFG.
  - Command handshake with cmd_size==0: set err_size; stay in IDLE; emit nothing.
- CFG: cfg_valid=1, with cfg_size/cfg_scheme equal to the captured values. Outputs hold stable while cfg_ready=0. On handshake go to PACK. cfg_valid rises the cycle after the command is accepted.
- PACK: in_ready=1. On each word handshake:
  - Write the word into block[511-32*slot -: 32]; slot 0 sits at [511:480].
  - If this is the final word (word_cnt==words_total-1) and rem!=0, keep only the upper rem bits and zero the rest.
  - word_cnt++, slot++ (4-bit, wraps after 15).
  - If the final word was accepted or slot==15, go to SEND.
- SEND: data_out_valid=1, in_ready=0, data_out held stable. On handshake:
  - Clear the block register to 0 and set slot=0.
  - If word_cnt==words_total, go to IDLE; otherwise go to PACK.
- Latency:
  - Block completion word accepted -> data_out_valid on the next cycle.
  - Blocks emitted per message = ceil(cmd_size/512), matching the engine's words_to_read.
- Throughput: at least one bubble per block (input stalls during SEND); this is acceptable.
- in_last checking:
  - in_last=1 on a non-final word, or in_last=0 on the final word: set err_last.
  - The data path is always governed by cmd_size; the word is still accepted and counted.
- Sticky errors clear only on reset.
- Command arriving while busy: cmd_ready=0; it waits.
- Reset mid-operation: immediate return to the reset values; any partial block is discarded. The engine must be reset together with this block.
- Ordering: cfg is always handed over before the first data block of the same message. This is required because the engine's data FIFO is 4 deep and it only pulls data after reading cfg.

Test Plan:
1. size=512; words 0x00000001..0x00000010, in_last on the 16th -> cfg_size=512. One block with 0x00000001 at [511:480] and 0x00000010 at [31:0]. Errors stay 0; returns to IDLE.
2. size=40; words 0xAABBCCDD, 0xFFFFFFFF(last) -> data_out[511:448]=0xAABBCCDD_FF000000, all lower bits 0.
3. size=1100 (35 words) -> 3 blocks. Block 3 holds words 32..34 at top, word 34 masked to its upper 12 bits (0xFFF00000 for input 0xFFFFFFFF), remainder zero.
4. Backpressure:
   - cfg_ready=0 for 5 cycles -> cfg fields stable, in_ready=0.
   - data_out_ready=0 for 7 cycles after a full block -> data_out stable, in_ready=0.
   - Release -> correct continuation, no lost or duplicated words.
5. Last-marker error:
   - size=256, in_last on word 3 -> err_last=1; all 8 words still accepted; one block emitted.
   - Next clean message keeps err_last=1 (sticky).
6. Zero size and reset:
   - size=0 -> err_size=1, no cfg_valid/data_out_valid, cmd_ready=1 next cycle.
   - nrst pulse mid-PACK (slot 5) -> all outputs at reset values; a following size=32 message completes normally.
